// File: rtl/sema_arbiter.sv
// Round-robin arbiter sharing a binary semaphore bank between cores; owner checking under SEMA_OWNER_CHECK_EN.
// Two cycles per op (IDLE grant, ACCESS update+ack); losers stall on suspend_cpu until their own ack.
module sema_arbiter #(
  parameter int NUM_CPUS = 4,
  parameter int NUM_SEMA = 16
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [NUM_CPUS-1:0]                   req,
  input  logic [NUM_CPUS-1:0]                   op,
  input  logic [NUM_CPUS*$clog2(NUM_SEMA)-1:0]  sema_id,
  output logic [NUM_CPUS-1:0]                   suspend_cpu,
  output logic [NUM_CPUS-1:0]                   ack,
  output logic [NUM_CPUS-1:0]                   sema_rdata,
  output logic [NUM_SEMA-1:0]                   sema_state,
  output logic [NUM_CPUS-1:0]                   owner_err
);

  localparam int ID_W  = $clog2(NUM_SEMA);
  localparam int WIN_W = $clog2(NUM_CPUS);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  typedef struct packed {
    logic [WIN_W-1:0] winner;
    logic             op;
    logic [ID_W-1:0]  id;
  } grant_t;

  state_t              state_q, state_d;
  grant_t              grant_q;
  logic [WIN_W-1:0]    rr_q;
  logic [WIN_W-1:0]    pick;
  logic                found;
  int                  scan_idx;
  logic [NUM_CPUS-1:0] pend;
  logic [NUM_CPUS-1:0] ack_q;
  logic [NUM_CPUS-1:0] rdata_q;
  logic [NUM_CPUS-1:0] err_q;
  logic [NUM_SEMA-1:0] bank_q;
  logic                old_bit;
  logic                bank_wr;
  logic                bank_val;
  logic                err_hit;

  // A core is masked in its own ack cycle so a held req is not served twice.
  assign pend        = req & ~ack_q;
  assign suspend_cpu = pend;
  assign ack         = ack_q;
  assign sema_rdata  = rdata_q;
  assign sema_state  = bank_q;
  assign owner_err   = err_q;

  always_comb begin
    pick     = rr_q;
    found    = 1'b0;
    scan_idx = 0;
    for (int k = 0; k < NUM_CPUS; k++) begin
      scan_idx = int'(rr_q) + k;
      if (scan_idx >= NUM_CPUS) scan_idx = scan_idx - NUM_CPUS;
      if (!found && pend[scan_idx]) begin
        pick  = WIN_W'(scan_idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (found) state_d = ACCESS;
      ACCESS: state_d = IDLE;
    endcase
  end

`ifdef SEMA_OWNER_CHECK_EN
  logic [WIN_W-1:0] owner_q [NUM_SEMA];
  logic             own_wr;
`endif

  always_comb begin
    old_bit  = bank_q[grant_q.id];
    bank_wr  = 1'b0;
    bank_val = ~grant_q.op;
    err_hit  = 1'b0;
`ifdef SEMA_OWNER_CHECK_EN
    own_wr   = 1'b0;
`endif
    if (state_q == ACCESS) begin
      bank_wr = 1'b1;
`ifdef SEMA_OWNER_CHECK_EN
      if (!grant_q.op && !old_bit) own_wr = 1'b1;
      // Non-owner release of a held bit is rejected; old_bit (1) is still returned.
      if (grant_q.op && old_bit && (owner_q[grant_q.id] != grant_q.winner)) begin
        bank_wr = 1'b0;
        err_hit = 1'b1;
      end
`endif
    end
  end

`ifdef SEMA_OWNER_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int s = 0; s < NUM_SEMA; s++) owner_q[s] <= '0;
    end else if (own_wr) begin
      owner_q[grant_q.id] <= grant_q.winner;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      grant_q <= '0;
      rr_q    <= '0;
      bank_q  <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      if (state_q == IDLE && found) begin
        grant_q.winner <= pick;
        grant_q.op     <= op[pick];
        grant_q.id     <= sema_id[pick*ID_W +: ID_W];
      end
      if (state_q == ACCESS) begin
        ack_q[grant_q.winner]   <= 1'b1;
        rdata_q[grant_q.winner] <= old_bit;
        err_q[grant_q.winner]   <= err_hit;
        rr_q <= (grant_q.winner == WIN_W'(NUM_CPUS - 1)) ? '0 : grant_q.winner + WIN_W'(1);
        if (bank_wr) bank_q[grant_q.id] <= bank_val;
      end
    end
  end

endmodule

// File: tb/tb_sema_arbiter.sv
// Directed bench for sema_arbiter (4 cores, 16 semaphores).
module tb_sema_arbiter;

  logic        clk;
  logic        rstn;
  logic [3:0]  req;
  logic [3:0]  op;
  logic [15:0] sema_id;
  logic [3:0]  suspend_cpu;
  logic [3:0]  ack;
  logic [3:0]  sema_rdata;
  logic [15:0] sema_state;
  logic [3:0]  owner_err;

  int checks = 0;
  int failures = 0;

  sema_arbiter #(.NUM_CPUS(4), .NUM_SEMA(16)) dut (
    .clk(clk), .rstn(rstn), .req(req), .op(op), .sema_id(sema_id),
    .suspend_cpu(suspend_cpu), .ack(ack), .sema_rdata(sema_rdata),
    .sema_state(sema_state), .owner_err(owner_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lone request: hold until ack, report rdata/owner_err at ack, cycles to ack and stall cycles.
  task automatic run_op(input int c, input logic o, input logic [3:0] id,
                        output logic rd, output int cyc, output int sc, output logic er);
    req[c] = 1'b1;
    op[c] = o;
    sema_id[c*4 +: 4] = id;
    #1;
    sc = suspend_cpu[c] ? 1 : 0;
    cyc = 0;
    while (ack[c] !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (ack[c] !== 1'b1 && suspend_cpu[c] === 1'b1) sc++;
    end
    rd = sema_rdata[c];
    er = owner_err[c];
    req[c] = 1'b0;
    @(posedge clk); #1;
  endtask

  logic rd, er;
  int   cyc, sc, n;
  int   order [4];
  logic rds   [4];

  initial begin
    rstn = 1'b0; req = '0; op = '0; sema_id = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", ack, 4'h0);
    chk("rst_state", sema_state, 16'h0000);
    chk("rst_rdata", sema_rdata, 4'h0);
    chk("rst_err", owner_err, 4'h0);
    req = 4'b0001; #1;
    chk("rst_suspend_follows_req", suspend_cpu, 4'b0001);
    req = '0;
    rstn = 1'b1;
    @(posedge clk); #1;

    // core0 acquires free id 3
    run_op(0, 1'b0, 4'd3, rd, cyc, sc, er);
    chk("t1_rdata", rd, 1'b0);
    chk("t1_latency", cyc, 2);
    chk("t1_suspend_cycles", sc, 2);
    chk("t1_state", sema_state, 16'h0008);
    chk("t1_ack_one_pulse", ack, 4'h0);

    // core1 acquires held id 3
    run_op(1, 1'b0, 4'd3, rd, cyc, sc, er);
    chk("t2_rdata", rd, 1'b1);
    chk("t2_state", sema_state, 16'h0008);
    chk("t2_rdata_held", sema_rdata, 4'b0010);

    // all four cores acquire id 5 together, rr_ptr is 2
    req = 4'hF; op = 4'h0; sema_id = 16'h5555;
    n = 0;
    for (int t = 0; t < 20 && n < 4; t++) begin
      @(posedge clk); #1;
      for (int c = 0; c < 4; c++) begin
        if (ack[c] === 1'b1 && n < 4) begin
          order[n] = c;
          rds[n] = sema_rdata[c];
          n++;
          req[c] = 1'b0;
        end
      end
    end
    req = '0;
    chk("t3_ack_count", n, 4);
    chk("t3_order0", order[0], 2);
    chk("t3_order1", order[1], 3);
    chk("t3_order2", order[2], 0);
    chk("t3_order3", order[3], 1);
    chk("t3_rd0", rds[0], 1'b0);
    chk("t3_rd1", rds[1], 1'b1);
    chk("t3_rd2", rds[2], 1'b1);
    chk("t3_rd3", rds[3], 1'b1);
    chk("t3_state", sema_state, 16'h0028);
    chk("t3_rr_ptr", dut.rr_q, 2);
    @(posedge clk); #1;

    // releases
    run_op(0, 1'b1, 4'd3, rd, cyc, sc, er);
    chk("t4_rel3_rdata", rd, 1'b1);
    chk("t4_rel3_state", sema_state, 16'h0020);
    run_op(2, 1'b1, 4'd5, rd, cyc, sc, er);
    chk("t4_rel5_rdata", rd, 1'b1);
    chk("t4_rel5_state", sema_state, 16'h0000);
    run_op(0, 1'b1, 4'd3, rd, cyc, sc, er);
    chk("t4_rel_clear_rdata", rd, 1'b0);
    chk("t4_rel_clear_state", sema_state, 16'h0000);

    // reset during ACCESS of core2 acquiring id 7
    req[2] = 1'b1; op[2] = 1'b0; sema_id[11:8] = 4'd7;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("t5_no_ack", ack, 4'h0);
    chk("t5_bank7", sema_state[7], 1'b0);
    chk("t5_rdata_cleared", sema_rdata, 4'h0);
    chk("t5_suspend", suspend_cpu, 4'b0100);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("t5_idle_grant_no_ack", ack, 4'h0);
    @(posedge clk); #1;
    chk("t5_retry_ack", ack, 4'b0100);
    chk("t5_retry_state", sema_state, 16'h0080);
    req = '0;
    @(posedge clk); #1;
    run_op(2, 1'b1, 4'd7, rd, cyc, sc, er);
    chk("t5_rel7_rdata", rd, 1'b1);
    chk("t5_rel7_state", sema_state, 16'h0000);

    // ownership
    run_op(0, 1'b0, 4'd1, rd, cyc, sc, er);
    chk("t6_acq_rdata", rd, 1'b0);
    chk("t6_acq_err", er, 1'b0);
`ifdef SEMA_OWNER_CHECK_EN
    run_op(1, 1'b1, 4'd1, rd, cyc, sc, er);
    chk("t6_foreign_rel_rdata", rd, 1'b1);
    chk("t6_foreign_rel_err", er, 1'b1);
    chk("t6_foreign_rel_state", sema_state, 16'h0002);
    chk("t6_err_one_pulse", owner_err, 4'h0);
    run_op(0, 1'b1, 4'd1, rd, cyc, sc, er);
    chk("t6_owner_rel_rdata", rd, 1'b1);
    chk("t6_owner_rel_err", er, 1'b0);
    chk("t6_owner_rel_state", sema_state, 16'h0000);
`else
    run_op(1, 1'b1, 4'd1, rd, cyc, sc, er);
    chk("t6_any_rel_rdata", rd, 1'b1);
    chk("t6_any_rel_err", er, 1'b0);
    chk("t6_any_rel_state", sema_state, 16'h0000);
    run_op(0, 1'b1, 4'd1, rd, cyc, sc, er);
    chk("t6_rel_clear_rdata", rd, 1'b0);
    chk("t6_rel_clear_state", sema_state, 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
